// File: rtl/vectadd_hs_ctrl.sv
// Avalon-MM run controller for the vectadd datapath: start strobe, done wait, run timing, timeout, flags.
// Optional interrupt logic is built only when VECTADD_HS_CTRL_IRQ_EN is defined; otherwise irq is tied low.
module vectadd_hs_ctrl #(
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hw_start,
    input  logic        hw_done,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       pulse_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] last_cnt;
    logic             done_flag;
    logic             to_flag;
    logic             irq_en_rd;
    logic [31:0]      rd_nxt;

    logic wr_en, start_wr, clear_wr, start_go, timeout_hit, set_done, set_to;

    assign wr_en       = chipselect & ~write_n;
    assign start_wr    = wr_en && (address == 2'd1) && writedata[0];
    assign clear_wr    = wr_en && (address == 2'd1) && writedata[1];
    assign start_go    = (state == IDLE) && start_wr;
    assign timeout_hit = (limit != '0) && (run_cnt == limit - CNT_W'(1));
    // hw_done has priority over a timeout landing on the same cycle
    assign set_to      = (state == RUN) && !hw_done && timeout_hit;
    assign set_done    = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_wr) state_nxt = PULSE;
            PULSE:   if (pulse_cnt == 4'(PULSE_LEN - 1)) state_nxt = RUN;
            RUN: begin
                if (hw_done)          state_nxt = DONE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hw_start  <= 1'b0;
            pulse_cnt <= '0;
            run_cnt   <= '0;
            last_cnt  <= '0;
            limit     <= '0;
            done_flag <= 1'b0;
            to_flag   <= 1'b0;
            readdata  <= '0;
        end else begin
            // Registered from next state so the strobe spans exactly the PULSE cycles
            hw_start  <= (state_nxt == PULSE);
            pulse_cnt <= (state == PULSE) ? pulse_cnt + 4'd1 : 4'd0;

            if (start_go)
                run_cnt <= '0;
            else if ((state == RUN) && !hw_done && (run_cnt != '1))
                run_cnt <= run_cnt + CNT_W'(1);

            if (set_to)
                last_cnt <= limit;
            else if (set_done)
                last_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);

            if (set_done)                  done_flag <= 1'b1;
            else if (start_go || clear_wr) done_flag <= 1'b0;

            if (set_to)                    to_flag <= 1'b1;
            else if (start_go || clear_wr) to_flag <= 1'b0;

            if (wr_en && (address == 2'd2))
                limit <= writedata[CNT_W-1:0];

            readdata <= rd_nxt;
        end
    end

`ifdef VECTADD_HS_CTRL_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (address == 2'd1))
                irq_en <= writedata[2];
            irq <= irq_en & (done_flag | to_flag);
        end
    end

    assign irq_en_rd = irq_en;
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_nxt = '0;
        case (address)
            2'd0: rd_nxt = {27'd0, state, to_flag, done_flag, (state != IDLE)};
            2'd1: rd_nxt = {29'd0, irq_en_rd, 2'b00};
            2'd2: rd_nxt = 32'(limit);
            2'd3: rd_nxt = 32'(last_cnt);
        endcase
    end

endmodule
